// File: rtl/decode_stage_if.sv
// Decode-stage bus bundle: D pipeline register in, forwarding sources, E pipeline register out.
interface decode_stage_if #(
  parameter int unsigned XLEN = 64
);
  // D pipeline register (from fetch)
  logic [3:0]      D_icode;
  logic [3:0]      D_ifun;
  logic [3:0]      D_rA;
  logic [3:0]      D_rB;
  logic [XLEN-1:0] D_valC;
  logic [XLEN-1:0] D_valP;
  logic [3:0]      D_stat;
  logic            E_bubble;

  // Forwarding / write-back sources
  logic [3:0]      e_dstE;
  logic [XLEN-1:0] e_valE;
  logic [3:0]      M_dstE;
  logic [XLEN-1:0] M_valE;
  logic [3:0]      M_dstM;
  logic [XLEN-1:0] m_valM;
  logic [3:0]      W_dstE;
  logic [XLEN-1:0] W_valE;
  logic [3:0]      W_dstM;
  logic [XLEN-1:0] W_valM;

  // Decode results
  logic [3:0]      d_srcA;
  logic [3:0]      d_srcB;
  logic [3:0]      E_icode;
  logic [3:0]      E_ifun;
  logic [XLEN-1:0] E_valC;
  logic [XLEN-1:0] E_valA;
  logic [XLEN-1:0] E_valB;
  logic [3:0]      E_dstE;
  logic [3:0]      E_dstM;
  logic [3:0]      E_srcA;
  logic [3:0]      E_srcB;
  logic [3:0]      E_stat;

  // Upstream/environment side
  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, E_bubble,
    output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
    output W_dstE, W_valE, W_dstM, W_valM,
    input  d_srcA, d_srcB,
    input  E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB, E_stat
  );

  // Decode stage side
  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, E_bubble,
    input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
    input  W_dstE, W_valE, W_dstM, W_valM,
    output d_srcA, d_srcB,
    output E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB, E_stat
  );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 decode / write-back stage: register file, operand select with
// E/M/W forwarding, and the E pipeline register with bubble insertion.
module decode_stage #(
  parameter int unsigned    XLEN     = 64,
  parameter logic [XLEN-1:0] RSP_INIT = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  localparam int unsigned NREG = 15;

  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h8;

  logic [XLEN-1:0] rf [NREG];

  logic [3:0]      src_a;
  logic [3:0]      src_b;
  logic [3:0]      dst_e;
  logic [3:0]      dst_m;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] val_a;
  logic [XLEN-1:0] val_b;

  // Register-id selection from icode; unknown icodes use no registers
  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;

    case (bus.D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.D_rA;
      I_RET, I_POPQ:                      src_a = R_RSP;
      default:                            ;
    endcase

    case (bus.D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = bus.D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = R_RSP;
      default:                            ;
    endcase

    case (bus.D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = bus.D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = R_RSP;
      default:                            ;
    endcase

    case (bus.D_icode)
      I_MRMOVQ, I_POPQ:                   dst_m = bus.D_rA;
      default:                            ;
    endcase
  end

  assign bus.d_srcA = src_a;
  assign bus.d_srcB = src_b;

  // Combinational register-file read; id F reads as zero
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (src_a != R_NONE) rf_a = rf[src_a];
    if (src_b != R_NONE) rf_b = rf[src_b];
  end

  // Operand A: valP for jXX/call, else forwarding chain youngest-first, else regfile
  always_comb begin
    val_a = rf_a;
    if (bus.D_icode == I_JXX || bus.D_icode == I_CALL) val_a = bus.D_valP;
    else if (src_a == R_NONE)                           val_a = '0;
    else if (src_a == bus.e_dstE)                       val_a = bus.e_valE;
    else if (src_a == bus.M_dstM)                       val_a = bus.m_valM;
    else if (src_a == bus.M_dstE)                       val_a = bus.M_valE;
    else if (src_a == bus.W_dstM)                       val_a = bus.W_valM;
    else if (src_a == bus.W_dstE)                       val_a = bus.W_valE;
  end

  // Operand B: same forwarding chain without the valP term
  always_comb begin
    val_b = rf_b;
    if (src_b == R_NONE)             val_b = '0;
    else if (src_b == bus.e_dstE)    val_b = bus.e_valE;
    else if (src_b == bus.M_dstM)    val_b = bus.m_valM;
    else if (src_b == bus.M_dstE)    val_b = bus.M_valE;
    else if (src_b == bus.W_dstM)    val_b = bus.W_valM;
    else if (src_b == bus.W_dstE)    val_b = bus.W_valE;
  end

  // Register-file write-back; the dstM write is last so it wins on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      rf[R_RSP] <= RSP_INIT;
    end else begin
      if (bus.W_dstE != R_NONE) rf[bus.W_dstE] <= bus.W_valE;
      if (bus.W_dstM != R_NONE) rf[bus.W_dstM] <= bus.W_valM;
    end
  end

  // E pipeline register; a bubble overrides whatever D holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.E_icode <= I_NOP;
      bus.E_ifun  <= 4'h0;
      bus.E_valC  <= '0;
      bus.E_valA  <= '0;
      bus.E_valB  <= '0;
      bus.E_dstE  <= R_NONE;
      bus.E_dstM  <= R_NONE;
      bus.E_srcA  <= R_NONE;
      bus.E_srcB  <= R_NONE;
      bus.E_stat  <= S_AOK;
    end else if (bus.E_bubble) begin
      bus.E_icode <= I_NOP;
      bus.E_ifun  <= 4'h0;
      bus.E_valC  <= '0;
      bus.E_valA  <= '0;
      bus.E_valB  <= '0;
      bus.E_dstE  <= R_NONE;
      bus.E_dstM  <= R_NONE;
      bus.E_srcA  <= R_NONE;
      bus.E_srcB  <= R_NONE;
      bus.E_stat  <= S_AOK;
    end else begin
      bus.E_icode <= bus.D_icode;
      bus.E_ifun  <= bus.D_ifun;
      bus.E_valC  <= bus.D_valC;
      bus.E_valA  <= val_a;
      bus.E_valB  <= val_b;
      bus.E_dstE  <= dst_e;
      bus.E_dstM  <= dst_m;
      bus.E_srcA  <= src_a;
      bus.E_srcB  <= src_b;
      bus.E_stat  <= bus.D_stat;
    end
  end

endmodule
